// File: rtl/ema_feed_scheduler.sv
// Per-stock price FIFOs feeding a single EMA engine through a round-robin arbiter.
// Engine results are realigned with the stock id carried in a local pipeline.
module ema_feed_scheduler #(
    parameter int NUM_STOCK  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic [NUM_STOCK-1:0]     req_valid,
    input  logic [6*NUM_STOCK-1:0]   req_price,
    output logic [NUM_STOCK-1:0]     req_ready,
    output logic                     ema_enable,
    output logic [7:0]               ema_data,
    input  logic                     ema_buy,
    input  logic                     ema_sell,
    output logic                     sig_valid,
    output logic                     sig_buy,
    output logic                     sig_sell,
    output logic [1:0]               sig_stock,
    output logic [15:0]              issued_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [5:0]           r_mem [NUM_STOCK][FIFO_DEPTH];
    logic [PW-1:0]        r_rd  [NUM_STOCK];
    logic [PW-1:0]        r_wr  [NUM_STOCK];
    logic [CW-1:0]        r_cnt [NUM_STOCK];
    logic [1:0]           r_rr_ptr;
    logic                 r_p1_valid;
    logic [1:0]           r_p1_stock;

    logic [NUM_STOCK-1:0] w_push;
    logic [NUM_STOCK-1:0] w_pop;
    logic [NUM_STOCK-1:0] w_nonempty;
    logic                 w_grant;
    logic [1:0]           w_gid;
    logic [1:0]           w_idx;
    logic [5:0]           w_head;

    // Ready reflects occupancy only, so a same-cycle pop never opens a slot early.
    always_comb begin
        req_ready  = '0;
        w_nonempty = '0;
        w_push     = '0;
        for (int unsigned i = 0; i < NUM_STOCK; i++) begin
            req_ready[i]  = (r_cnt[i] < FULL_CNT);
            w_nonempty[i] = (r_cnt[i] != '0);
            w_push[i]     = req_valid[i] & req_ready[i];
        end
    end

    always_comb begin
        w_grant = 1'b0;
        w_gid   = '0;
        w_idx   = '0;
        w_pop   = '0;
        if (run) begin
            for (int unsigned k = 0; k < NUM_STOCK; k++) begin
                w_idx = r_rr_ptr + 2'(k);
                if (!w_grant && w_nonempty[w_idx]) begin
                    w_grant = 1'b1;
                    w_gid   = w_idx;
                end
            end
        end
        for (int unsigned i = 0; i < NUM_STOCK; i++) begin
            w_pop[i] = w_grant && (w_gid == 2'(i));
        end
    end

    assign w_head = r_mem[w_gid][r_rd[w_gid]];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_STOCK; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr[i]] <= req_price[6*i +: 6];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_STOCK; i++) begin
                r_rd[i]  <= '0;
                r_wr[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_STOCK; i++) begin
                if (w_push[i]) begin
                    r_wr[i] <= (r_wr[i] == LAST_PTR) ? '0 : r_wr[i] + 1'b1;
                end
                if (w_pop[i]) begin
                    r_rd[i] <= (r_rd[i] == LAST_PTR) ? '0 : r_rd[i] + 1'b1;
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
                    2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ema_enable   <= 1'b0;
            ema_data     <= '0;
            r_rr_ptr     <= '0;
            issued_count <= '0;
        end else begin
            ema_enable <= w_grant;
            if (w_grant) begin
                ema_data     <= {w_gid, w_head};
                r_rr_ptr     <= w_gid + 2'd1;
                issued_count <= issued_count + 16'd1;
            end
        end
    end

    // Engine flags land one cycle after the issue; r_p1_* lines the stock id up with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_valid <= 1'b0;
            r_p1_stock <= '0;
            sig_valid  <= 1'b0;
            sig_buy    <= 1'b0;
            sig_sell   <= 1'b0;
            sig_stock  <= '0;
        end else begin
            r_p1_valid <= ema_enable;
            r_p1_stock <= ema_data[7:6];
            sig_valid  <= r_p1_valid;
            sig_buy    <= r_p1_valid & ema_buy;
            sig_sell   <= r_p1_valid & ema_sell;
            sig_stock  <= r_p1_valid ? r_p1_stock : '0;
        end
    end

endmodule

// File: tb/tb_ema_feed_scheduler.sv
// Self-checking bench for ema_feed_scheduler: scenario tasks plus a scoreboard
// of expected engine words and results, with a simple registered engine model.
module tb_ema_feed_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [23:0] req_price = '0;
    logic [3:0]  req_ready;
    logic        ema_enable;
    logic [7:0]  ema_data;
    logic        ema_buy = 1'b0;
    logic        ema_sell = 1'b0;
    logic        sig_valid, sig_buy, sig_sell;
    logic [1:0]  sig_stock;
    logic [15:0] issued_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [1:0] stock;
        logic       buy;
        logic       sell;
        int         due;
    } res_t;

    logic [7:0] exp_issue[$];
    res_t       res_q[$];

    logic       eng_en = 1'b0;
    logic [7:0] eng_d = '0;

    ema_feed_scheduler #(.NUM_STOCK(4), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .run(run),
        .req_valid(req_valid), .req_price(req_price), .req_ready(req_ready),
        .ema_enable(ema_enable), .ema_data(ema_data),
        .ema_buy(ema_buy), .ema_sell(ema_sell),
        .sig_valid(sig_valid), .sig_buy(sig_buy), .sig_sell(sig_sell),
        .sig_stock(sig_stock), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Engine model: registered flags derived from the sampled word; noise when idle.
    always @(negedge clk) begin
        eng_en = ema_enable;
        eng_d  = ema_data;
    end

    always @(posedge clk) begin
        #1;
        if (eng_en) begin
            ema_buy  = eng_d[0];
            ema_sell = eng_d[1];
        end else begin
            ema_buy  = 1'($urandom);
            ema_sell = 1'($urandom);
        end
    end

    always @(negedge clk) begin : mon
        logic [7:0] e;
        res_t r;
        if (!rst) begin
            if (ema_enable) begin
                checks++;
                if (exp_issue.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected: ema_data=%h, none expected (cyc %0d)", ema_data, cyc);
                end else begin
                    e = exp_issue.pop_front();
                    if (ema_data !== e) begin
                        errors++;
                        $display("FAIL issue_data: got %h expected %h (cyc %0d)", ema_data, e, cyc);
                    end
                    r.stock = e[7:6];
                    r.buy   = e[0];
                    r.sell  = e[1];
                    r.due   = cyc + 2;
                    res_q.push_back(r);
                end
            end
            if (sig_valid) begin
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_unexpected: stock=%0d buy=%b sell=%b (cyc %0d)", sig_stock, sig_buy, sig_sell, cyc);
                end else begin
                    r = res_q.pop_front();
                    if (sig_stock !== r.stock || sig_buy !== r.buy || sig_sell !== r.sell || cyc != r.due) begin
                        errors++;
                        $display("FAIL result: got stock=%0d buy=%b sell=%b cyc=%0d expected stock=%0d buy=%b sell=%b cyc=%0d",
                                 sig_stock, sig_buy, sig_sell, cyc, r.stock, r.buy, r.sell, r.due);
                    end
                end
            end else begin
                checks++;
                if (sig_buy !== 1'b0 || sig_sell !== 1'b0) begin
                    errors++;
                    $display("FAIL sig_idle: buy=%b sell=%b expected 0 0 (cyc %0d)", sig_buy, sig_sell, cyc);
                end
                if (res_q.size() > 0 && res_q[0].due <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL result_missing: sig_valid=0 expected result for stock %0d at cyc %0d", res_q[0].stock, res_q[0].due);
                    void'(res_q.pop_front());
                end
            end
        end
    end

    function automatic logic [5:0] rr_price(int s, int j);
        return 6'(s * 16 + j * 5 + 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_issue(logic [1:0] s, logic [5:0] p);
        exp_issue.push_back({s, p});
        exp_cnt++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (ema_enable !== 1'b0) begin errors++; $display("FAIL rst_ema_enable: got %b expected 0", ema_enable); end
        checks++; if (ema_data !== 8'h00) begin errors++; $display("FAIL rst_ema_data: got %h expected 00", ema_data); end
        checks++; if ({sig_valid, sig_buy, sig_sell} !== 3'b000) begin errors++; $display("FAIL rst_sig: got %b expected 000", {sig_valid, sig_buy, sig_sell}); end
        checks++; if (sig_stock !== 2'd0) begin errors++; $display("FAIL rst_sig_stock: got %0d expected 0", sig_stock); end
        checks++; if (issued_count !== 16'd0) begin errors++; $display("FAIL rst_issued: got %0d expected 0", issued_count); end
        checks++; if (req_ready !== 4'hF) begin errors++; $display("FAIL rst_ready: got %b expected 1111", req_ready); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 4'hF) begin errors++; $display("FAIL post_rst_ready: got %b expected 1111", req_ready); end
        checks++; if (ema_enable !== 1'b0) begin errors++; $display("FAIL post_rst_enable: got %b expected 0", ema_enable); end
    endtask

    task automatic test_round_robin();
        tick();
        run = 1'b0;
        req_valid = 4'hF;
        for (int s = 0; s < 4; s++) begin
            req_price[6*s +: 6] = rr_price(s, 0);
            expect_issue(2'(s), rr_price(s, 0));
        end
        tick();
        for (int s = 0; s < 4; s++) begin
            req_price[6*s +: 6] = rr_price(s, 1);
            expect_issue(2'(s), rr_price(s, 1));
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rr_full_ready: got %b expected 0000", req_ready); end
        checks++; if (ema_enable !== 1'b0) begin errors++; $display("FAIL rr_idle_enable: got %b expected 0", ema_enable); end
        tick();
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ema_enable !== 1'b1) begin errors++; $display("FAIL rr_throughput: cycle %0d ema_enable=%b expected 1", i, ema_enable); end
        end
        @(posedge clk);
        @(negedge clk);
        checks++; if (ema_enable !== 1'b0) begin errors++; $display("FAIL rr_drained_enable: got %b expected 0", ema_enable); end
        checks++; if (ema_data !== {2'd3, rr_price(3, 1)}) begin errors++; $display("FAIL rr_data_hold: got %h expected %h", ema_data, {2'd3, rr_price(3, 1)}); end
        checks++; if (issued_count !== 16'(exp_cnt)) begin errors++; $display("FAIL rr_issued: got %0d expected %0d", issued_count, exp_cnt); end
        checks++; if (req_ready !== 4'hF) begin errors++; $display("FAIL rr_ready_after: got %b expected 1111", req_ready); end
    endtask

    task automatic test_single_issue();
        tick();
        run = 1'b1;
        req_valid[2] = 1'b1;
        req_price[12 +: 6] = 6'h15;
        expect_issue(2'd2, 6'h15);
        tick();
        req_valid[2] = 1'b0;
        @(negedge clk);
        checks++; if (ema_enable !== 1'b0) begin errors++; $display("FAIL single_no_bypass: ema_enable=%b expected 0", ema_enable); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (ema_enable !== 1'b1) begin errors++; $display("FAIL single_enable: got %b expected 1", ema_enable); end
        checks++; if (ema_data !== 8'h95) begin errors++; $display("FAIL single_data: got %h expected 95", ema_data); end
        repeat (4) tick();
        checks++; if (issued_count !== 16'(exp_cnt)) begin errors++; $display("FAIL single_issued: got %0d expected %0d", issued_count, exp_cnt); end
    endtask

    task automatic test_backpressure();
        logic acc;
        tick();
        run = 1'b0;
        req_valid[1] = 1'b1;
        req_price[6 +: 6] = 6'h21;
        expect_issue(2'd1, 6'h21);
        tick();
        req_price[6 +: 6] = 6'h0A;
        expect_issue(2'd1, 6'h0A);
        tick();
        @(negedge clk);
        checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", req_ready[1]); end
        req_price[6 +: 6] = 6'h33;
        expect_issue(2'd1, 6'h33);
        tick();
        @(negedge clk);
        checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_ready_held: got %b expected 0", req_ready[1]); end
        checks++; if (ema_enable !== 1'b0) begin errors++; $display("FAIL bp_run_low_enable: got %b expected 0", ema_enable); end
        tick();
        run = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acc = req_ready[1];
            tick();
            if (acc) break;
        end
        req_valid[1] = 1'b0;
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL bp_accept_timeout: req_ready[1]=0 for 10 cycles, expected 1"); end
        repeat (5) tick();
        checks++; if (issued_count !== 16'(exp_cnt)) begin errors++; $display("FAIL bp_issued: got %0d expected %0d", issued_count, exp_cnt); end
    endtask

    task automatic test_push_pop_same();
        logic [5:0] p [3];
        p[0] = 6'h3C;
        p[1] = 6'h01;
        p[2] = 6'h2E;
        tick();
        run = 1'b1;
        req_valid[3] = 1'b1;
        req_price[18 +: 6] = p[0];
        expect_issue(2'd3, p[0]);
        tick();
        for (int i = 1; i < 3; i++) begin
            req_price[18 +: 6] = p[i];
            expect_issue(2'd3, p[i]);
            @(negedge clk);
            checks++; if (req_ready[3] !== 1'b1) begin errors++; $display("FAIL pp_ready: step %0d got %b expected 1", i, req_ready[3]); end
            tick();
        end
        req_valid[3] = 1'b0;
        @(negedge clk);
        checks++; if (req_ready[3] !== 1'b1) begin errors++; $display("FAIL pp_ready_end: got %b expected 1", req_ready[3]); end
        repeat (5) tick();
        checks++; if (issued_count !== 16'(exp_cnt)) begin errors++; $display("FAIL pp_issued: got %0d expected %0d", issued_count, exp_cnt); end
    endtask

    task automatic test_run_drop();
        tick();
        run = 1'b0;
        req_valid[0] = 1'b1;
        req_price[0 +: 6] = 6'h03;
        expect_issue(2'd0, 6'h03);
        tick();
        req_price[0 +: 6] = 6'h11;
        tick();
        req_valid[0] = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        @(negedge clk);
        checks++; if (ema_enable !== 1'b1) begin errors++; $display("FAIL drop_issue: ema_enable=%b expected 1", ema_enable); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ema_enable !== 1'b0) begin errors++; $display("FAIL drop_no_issue: cycle %0d ema_enable=%b expected 0", i, ema_enable); end
        end
    endtask

    task automatic test_reset_mid();
        tick();
        run = 1'b0;
        req_valid = 4'b0011;
        req_price[0 +: 6] = 6'h2A;
        req_price[6 +: 6] = 6'h16;
        tick();
        req_valid = 4'b0010;
        req_price[6 +: 6] = 6'h39;
        tick();
        req_valid = '0;
        run = 1'b1;
        expect_issue(2'd1, 6'h16);
        tick();
        run = 1'b0;
        @(negedge clk);
        checks++; if (ema_enable !== 1'b1) begin errors++; $display("FAIL mid_issue: ema_enable=%b expected 1", ema_enable); end
        tick();
        rst = 1'b1;
        exp_issue.delete();
        res_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        checks++; if ({ema_enable, sig_valid, sig_buy, sig_sell} !== 4'b0000) begin errors++; $display("FAIL mid_rst_flags: got %b expected 0000", {ema_enable, sig_valid, sig_buy, sig_sell}); end
        checks++; if (ema_data !== 8'h00 || sig_stock !== 2'd0) begin errors++; $display("FAIL mid_rst_data: ema_data=%h sig_stock=%0d expected 00 0", ema_data, sig_stock); end
        checks++; if (issued_count !== 16'd0) begin errors++; $display("FAIL mid_rst_issued: got %0d expected 0", issued_count); end
        checks++; if (req_ready !== 4'hF) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1111", req_ready); end
        tick();
        rst = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ema_enable !== 1'b0) begin errors++; $display("FAIL mid_post_issue: cycle %0d ema_enable=%b expected 0", i, ema_enable); end
            @(posedge clk);
        end
        @(negedge clk);
        checks++; if (issued_count !== 16'd0) begin errors++; $display("FAIL mid_post_issued: got %0d expected 0", issued_count); end
        checks++; if (ema_data !== 8'h00) begin errors++; $display("FAIL mid_post_data: got %h expected 00", ema_data); end
        checks++; if (req_ready !== 4'hF) begin errors++; $display("FAIL mid_post_ready: got %b expected 1111", req_ready); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_issue();
        test_backpressure();
        test_push_pop_same();
        test_run_drop();
        test_reset_mid();
        repeat (4) tick();
        checks++;
        if (exp_issue.size() != 0 || res_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: issues=%0d results=%0d pending, expected 0 0", exp_issue.size(), res_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
